// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, post-redirect flush, data-memory freeze.
// Optional HAZARD_PERF_EN adds saturating perf_stall / perf_flush event counters.
module hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic              id_i,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_jump,
  input  logic              ex_br_taken,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              stall_flush,
  output logic [1:0]        hz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, FLUSH = 2'd2, MWAIT = 2'd3} hz_state_e;

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rs1_used, rs2_used, load_use, redirect;
  logic       pc_c, en_c, fl_c, st_c;

  assign rs1_used = id_opcode inside {[5'd1:5'd6], [5'd9:5'd14], 5'd16};
  assign rs2_used = ((id_opcode inside {[5'd1:5'd6], 5'd16}) && !id_i) || (id_opcode == 5'd11);
  assign load_use = id_valid && ex_mem_read && (ex_rd != '0) &&
                    ((rs1_used && (id_rs1 == ex_rd)) || (rs2_used && (id_rs2 == ex_rd)));
  assign redirect = ex_jump || ex_br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_c    = 1'b1;
    en_c    = 1'b1;
    fl_c    = 1'b0;
    st_c    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          pc_c    = 1'b0;
          en_c    = 1'b0;
          state_d = MWAIT;
        end else if (redirect) begin
          fl_c    = 1'b1;
          st_c    = 1'b1;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
          state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (load_use) begin
          pc_c    = 1'b0;
          en_c    = 1'b0;
          st_c    = 1'b1;
          state_d = LDSTALL;
        end
      end
      // EX holds the injected bubble, so only a memory freeze can intervene here
      LDSTALL: begin
        if (mem_busy) begin
          pc_c    = 1'b0;
          en_c    = 1'b0;
          state_d = MWAIT;
        end else begin
          state_d = RUN;
        end
      end
      // Redirects seen here come from wrong-path instructions and are ignored
      FLUSH: begin
        fl_c = 1'b1;
        st_c = 1'b1;
        if (mem_busy) begin
          pc_c = 1'b0;
          en_c = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = RUN;
        end
      end
      MWAIT: begin
        pc_c = 1'b0;
        en_c = 1'b0;
        if (!mem_busy) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign pc_en       = rst_n && pc_c;
  assign if_id_en    = rst_n && en_c;
  assign if_id_flush = !rst_n || fl_c;
  assign stall_flush = !rst_n || st_c;
  assign hz_state    = rst_n ? state_q : 2'd0;

`ifdef HAZARD_PERF_EN
  logic lds_evt, flush_evt;
  assign lds_evt   = (state_q == RUN) && !mem_busy && !redirect && load_use;
  assign flush_evt = (state_q == RUN) && !mem_busy && redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (lds_evt && !(&perf_stall))   perf_stall <= perf_stall + 1'b1;
      if (flush_evt && !(&perf_flush)) perf_flush <= perf_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: cycle-level behavioural model plus directed literal checks.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_i, ex_mem_read, ex_jump, ex_br_taken, mem_busy;
  logic [4:0]    id_opcode;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          pc_en, if_id_en, if_id_flush, stall_flush;
  logic [1:0]    hz_state;
`ifdef HAZARD_PERF_EN
  logic [15:0]   perf_stall, perf_flush;
`endif

  int n_chk = 0;
  int n_fail = 0;

  hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(FC), .PERF_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_i(id_i),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_jump(ex_jump), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .stall_flush(stall_flush), .hz_state(hz_state)
`ifdef HAZARD_PERF_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit uses1(input logic [4:0] op);
    return (op >= 5'd1 && op <= 5'd6) || (op >= 5'd9 && op <= 5'd14) || op == 5'd16;
  endfunction

  function automatic bit uses2(input logic [4:0] op, input logic imm);
    return (((op >= 5'd1 && op <= 5'd6) || op == 5'd16) && !imm) || op == 5'd11;
  endfunction

  // Model: waiting on memory, flush cycles still owed, bubble just injected
  bit m_wait, m_stall;
  int m_left;
  int p_stall, p_flush;

  always @(negedge clk) begin
    bit e_pc, e_en, e_fl, e_st, lu;
    int e_hz;
    if (!rst_n) begin
      e_pc = 0; e_en = 0; e_fl = 1; e_st = 1; e_hz = 0;
      m_wait = 0; m_stall = 0; m_left = 0; p_stall = 0; p_flush = 0;
    end else begin
      lu = id_valid && ex_mem_read && ex_rd != 0 &&
           ((uses1(id_opcode) && id_rs1 == ex_rd) || (uses2(id_opcode, id_i) && id_rs2 == ex_rd));
      e_pc = 1; e_en = 1; e_fl = 0; e_st = 0;
      e_hz = m_wait ? 3 : (m_left > 0) ? 2 : m_stall ? 1 : 0;
    end
`ifdef HAZARD_PERF_EN
    chk("m_perf_stall", perf_stall, p_stall);
    chk("m_perf_flush", perf_flush, p_flush);
`endif
    if (rst_n) begin
      if (m_wait) begin
        e_pc = 0; e_en = 0;
        m_wait = mem_busy;
      end else if (m_left > 0) begin
        e_fl = 1; e_st = 1;
        if (mem_busy) begin e_pc = 0; e_en = 0; end
        else m_left--;
      end else if (mem_busy) begin
        e_pc = 0; e_en = 0; m_wait = 1; m_stall = 0;
      end else if (m_stall) begin
        m_stall = 0;
      end else if (ex_jump || ex_br_taken) begin
        e_fl = 1; e_st = 1; m_left = FC - 1;
        if (p_flush < 65535) p_flush++;
      end else if (lu) begin
        e_pc = 0; e_en = 0; e_st = 1; m_stall = 1;
        if (p_stall < 65535) p_stall++;
      end
    end
    chk("m_pc_en", pc_en, e_pc);
    chk("m_if_id_en", if_id_en, e_en);
    chk("m_if_id_flush", if_id_flush, e_fl);
    chk("m_stall_flush", stall_flush, e_st);
    chk("m_hz_state", hz_state, e_hz);
  end

  task automatic drv(input bit v, input logic [4:0] op, input bit imm, input int r1, input int r2,
                     input bit mr, input int rd, input bit jmp, input bit br, input bit busy);
    id_valid = v; id_opcode = op; id_i = imm; id_rs1 = AW'(r1); id_rs2 = AW'(r2);
    ex_mem_read = mr; ex_rd = AW'(rd); ex_jump = jmp; ex_br_taken = br; mem_busy = busy;
  endtask

  task automatic idle(input bit jmp, input bit br, input bit busy);
    drv(0, 5'd0, 0, 0, 0, 0, 0, jmp, br, busy);
  endtask

  task automatic lit(input string nm, input bit pc, input bit en, input bit fl, input bit st, input int hz);
    @(negedge clk);
    chk({nm, ".pc_en"}, pc_en, pc);
    chk({nm, ".if_id_en"}, if_id_en, en);
    chk({nm, ".if_id_flush"}, if_id_flush, fl);
    chk({nm, ".stall_flush"}, stall_flush, st);
    chk({nm, ".hz_state"}, hz_state, hz);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1, 5'd1, 0, 3, 3, 1, 3, 1, 1, 1);
    lit("reset_junk", 0, 0, 1, 1, 0);
    rst_n = 1'b1;
    idle(0, 0, 0);                          lit("idle", 1, 1, 0, 0, 0);

    drv(1, 5'd1, 0, 3, 5, 1, 3, 0, 0, 0);   lit("lu_rs1", 0, 0, 0, 1, 0);
    drv(1, 5'd1, 0, 3, 5, 0, 0, 0, 0, 0);   lit("lu_bubble", 1, 1, 0, 0, 1);
    idle(0, 0, 0);                          lit("lu_back", 1, 1, 0, 0, 0);
    drv(1, 5'd1, 0, 0, 0, 1, 0, 0, 0, 0);   lit("load_r0", 1, 1, 0, 0, 0);
    drv(1, 5'd1, 1, 7, 3, 1, 3, 0, 0, 0);   lit("addi_rs2", 1, 1, 0, 0, 0);
    drv(1, 5'd11, 1, 7, 3, 1, 3, 0, 0, 0);  lit("store_rs2", 0, 0, 0, 1, 0);
    drv(1, 5'd11, 1, 7, 3, 0, 0, 0, 0, 0);  lit("store_bub", 1, 1, 0, 0, 1);
    drv(1, 5'd15, 0, 3, 3, 1, 3, 0, 0, 0);  lit("br_nosrc", 1, 1, 0, 0, 0);
    drv(0, 5'd1, 0, 3, 3, 1, 3, 0, 0, 0);   lit("id_invalid", 1, 1, 0, 0, 0);
    drv(1, 5'd8, 0, 3, 3, 1, 3, 0, 0, 0);   lit("jmp_nosrc", 1, 1, 0, 0, 0);
    drv(1, 5'd1, 0, 3, 3, 0, 3, 0, 0, 0);   lit("no_load", 1, 1, 0, 0, 0);
    drv(1, 5'd2, 0, 9, 3, 1, 3, 0, 0, 0);   lit("lu_rs2", 0, 0, 0, 1, 0);
    drv(1, 5'd2, 0, 9, 3, 0, 0, 0, 0, 0);   lit("lu_rs2_bub", 1, 1, 0, 0, 1);

    idle(0, 1, 0);                          lit("br_take", 1, 1, 1, 1, 0);
    idle(1, 0, 0);                          lit("br_flush", 1, 1, 1, 1, 2);
    idle(0, 0, 0);                          lit("br_done", 1, 1, 0, 0, 0);

    for (int k = 0; k < 3; k++) begin
      idle(1, 0, 1);                        lit("busy_jmp", 0, 0, 0, 0, (k == 0) ? 0 : 3);
    end
    idle(1, 0, 0);                          lit("busy_resume", 0, 0, 0, 0, 3);
    idle(1, 0, 0);                          lit("busy_redir", 1, 1, 1, 1, 0);
    idle(0, 0, 0);                          lit("busy_flush", 1, 1, 1, 1, 2);
    idle(0, 0, 0);                          lit("busy_done", 1, 1, 0, 0, 0);

    idle(0, 1, 0);                          lit("fb_take", 1, 1, 1, 1, 0);
    idle(0, 0, 1);                          lit("fb_hold1", 0, 0, 1, 1, 2);
    idle(0, 0, 1);                          lit("fb_hold2", 0, 0, 1, 1, 2);
    idle(0, 0, 0);                          lit("fb_last", 1, 1, 1, 1, 2);
    idle(0, 0, 0);                          lit("fb_done", 1, 1, 0, 0, 0);

    drv(1, 5'd1, 0, 3, 5, 1, 3, 0, 0, 0);   lit("lb_stall", 0, 0, 0, 1, 0);
    drv(1, 5'd1, 0, 3, 5, 0, 0, 0, 0, 1);   lit("lb_busy", 0, 0, 0, 0, 1);
    drv(1, 5'd1, 0, 3, 5, 0, 0, 0, 0, 0);   lit("lb_resume", 0, 0, 0, 0, 3);
    drv(1, 5'd1, 0, 3, 5, 0, 0, 0, 0, 0);   lit("lb_run", 1, 1, 0, 0, 0);

    drv(1, 5'd1, 0, 3, 5, 1, 3, 1, 0, 0);   lit("lu_vs_jmp", 1, 1, 1, 1, 0);
    idle(0, 0, 0);                          lit("lu_vs_jmp_fl", 1, 1, 1, 1, 2);
    idle(0, 0, 0);                          lit("lu_vs_jmp_done", 1, 1, 0, 0, 0);

    idle(0, 1, 0);                          lit("rf_take", 1, 1, 1, 1, 0);
    rst_n = 1'b0; idle(0, 0, 0);            lit("rf_reset", 0, 0, 1, 1, 0);
    rst_n = 1'b1;                           lit("rf_after", 1, 1, 0, 0, 0);

    idle(0, 0, 1);                          lit("rm_freeze", 0, 0, 0, 0, 0);
    idle(0, 0, 1);                          lit("rm_wait", 0, 0, 0, 0, 3);
    rst_n = 1'b0;                           lit("rm_reset", 0, 0, 1, 1, 0);
    rst_n = 1'b1; idle(0, 0, 0);            lit("rm_after", 1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
